// File: rtl/avalon_mxs_xbar.sv
// NM x NS Avalon-MM crossbar: per-slave decode, round-robin arbitration with grant lock, unmapped-address error path.
// Optional macro AVN_XBAR_TIMEOUT_EN adds a per-slave stall watchdog that forces completion with 0xDEAD_BEEF.
module avalon_mxs_xbar #(
  parameter int NM = 3,
  parameter int NS = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [NS*AW-1:0] SLV_BASE = {32'h8000_0000, 32'h0000_0000},
  parameter logic [NS*AW-1:0] SLV_MASK = {32'hF000_0000, 32'hF000_0000},
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NM-1:0]        m_read,
  input  logic [NM-1:0]        m_write,
  input  logic [NM*AW-1:0]     m_address,
  input  logic [NM*DW/8-1:0]   m_byte_enable,
  input  logic [NM*DW-1:0]     m_writedata,
  output logic [NM*DW-1:0]     m_readdata,
  output logic [NM-1:0]        m_waitrequest,
  output logic [NS-1:0]        s_read,
  output logic [NS-1:0]        s_write,
  output logic [NS*AW-1:0]     s_address,
  output logic [NS*DW/8-1:0]   s_byte_enable,
  output logic [NS*DW-1:0]     s_writedata,
  input  logic [NS*DW-1:0]     s_readdata,
  input  logic [NS-1:0]        s_waitrequest,
  output logic                 decode_err,
  output logic                 timeout_irq
);

  localparam int BW = DW / 8;
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  logic [NM-1:0] m_req, m_hit, err_q, err_d;
  logic [SW-1:0] m_sel [NM];
  logic [NS-1:0] busy_q, busy_d, arb_vld, own_rd, own_wr, own_req, xfer_done, tmo_fire;
  logic [IW-1:0] owner_q [NS];
  logic [IW-1:0] owner_d [NS];
  logic [IW-1:0] last_q  [NS];
  logic [IW-1:0] last_d  [NS];
  logic [IW-1:0] arb_win [NS];

  assign m_req = m_read | m_write;

  // Descending scan so the lowest-indexed matching slave is the one left standing.
  always_comb begin
    for (int i = 0; i < NM; i++) begin
      m_hit[i] = 1'b0;
      m_sel[i] = '0;
      for (int j = NS - 1; j >= 0; j--) begin
        if ((m_address[i*AW +: AW] & SLV_MASK[j*AW +: AW]) == SLV_BASE[j*AW +: AW]) begin
          m_hit[i] = 1'b1;
          m_sel[i] = SW'(j);
        end
      end
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int j = 0; j < NS; j++) begin
      arb_vld[j] = 1'b0;
      arb_win[j] = '0;
      for (int k = 1; k <= NM; k++) begin
        idx = (int'(last_q[j]) + k) % NM;
        if (!arb_vld[j] && m_req[idx] && m_hit[idx] && (m_sel[idx] == SW'(j))) begin
          arb_vld[j] = 1'b1;
          arb_win[j] = IW'(idx);
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NS; j++) begin
      own_rd[j]    = m_read[owner_q[j]];
      own_wr[j]    = m_write[owner_q[j]];
      own_req[j]   = own_rd[j] | own_wr[j];
      xfer_done[j] = busy_q[j] & own_req[j] & ~s_waitrequest[j];
    end
  end

`ifdef AVN_XBAR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q [NS];
  logic [CW-1:0] cnt_d [NS];

  always_comb begin
    for (int j = 0; j < NS; j++) begin
      tmo_fire[j] = busy_q[j] && (cnt_q[j] == CW'(TIMEOUT));
      cnt_d[j]    = cnt_q[j];
      if (!busy_q[j])
        cnt_d[j] = '0;
      else if (s_waitrequest[j] && !tmo_fire[j])
        cnt_d[j] = CW'(cnt_q[j] + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NS; j++) cnt_q[j] <= '0;
    end else begin
      for (int j = 0; j < NS; j++) cnt_q[j] <= cnt_d[j];
    end
  end

  assign timeout_irq = |tmo_fire;
`else
  assign tmo_fire    = '0;
  assign timeout_irq = 1'b0;
`endif

  // Grant lock: a busy slave ignores new requests until its owner completes or abandons.
  always_comb begin
    for (int j = 0; j < NS; j++) begin
      busy_d[j]  = busy_q[j];
      owner_d[j] = owner_q[j];
      last_d[j]  = last_q[j];
      if (!busy_q[j]) begin
        if (arb_vld[j]) begin
          busy_d[j]  = 1'b1;
          owner_d[j] = arb_win[j];
        end
      end else if (xfer_done[j] || tmo_fire[j]) begin
        busy_d[j] = 1'b0;
        last_d[j] = owner_q[j];
      end else if (!own_req[j]) begin
        busy_d[j] = 1'b0;
      end
    end
    err_d = m_req & ~m_hit & ~err_q;
  end

  always_comb begin
    s_read        = '0;
    s_write       = '0;
    s_address     = '0;
    s_byte_enable = '0;
    s_writedata   = '0;
    m_waitrequest = '1;
    m_readdata    = '0;
    for (int j = 0; j < NS; j++) begin
      if (busy_q[j]) begin
        s_read[j]                   = own_rd[j] & ~own_wr[j] & ~tmo_fire[j];
        s_write[j]                  = own_wr[j] & ~tmo_fire[j];
        s_address[j*AW +: AW]       = m_address[int'(owner_q[j])*AW +: AW];
        s_byte_enable[j*BW +: BW]   = m_byte_enable[int'(owner_q[j])*BW +: BW];
        s_writedata[j*DW +: DW]     = m_writedata[int'(owner_q[j])*DW +: DW];
        m_waitrequest[owner_q[j]]   = tmo_fire[j] ? 1'b0 : s_waitrequest[j];
        m_readdata[int'(owner_q[j])*DW +: DW] = tmo_fire[j] ? DW'(32'hDEAD_BEEF)
                                                            : s_readdata[j*DW +: DW];
      end
    end
    for (int i = 0; i < NM; i++) begin
      if (err_q[i] && m_req[i]) begin
        m_waitrequest[i]        = 1'b0;
        m_readdata[i*DW +: DW]  = '0;
      end
    end
  end

  assign decode_err = |(err_q & m_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= '0;
      for (int j = 0; j < NS; j++) begin
        owner_q[j] <= '0;
        last_q[j]  <= IW'(NM - 1);
      end
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
      for (int j = 0; j < NS; j++) begin
        owner_q[j] <= owner_d[j];
        last_q[j]  <= last_d[j];
      end
    end
  end

endmodule
